// File: rtl/chorus_delay_ctrl.sv
// chorus_delay_ctrl: sequences one delay_buffer for a chorus effect.
// Accepts a sample (in_*), writes it to the buffer with a one-cycle strobe,
// captures the delayed sample, and emits the dry/wet average (out_*).
// The buffer's extra read delay is driven from a triangle LFO that steps
// once per output handshake while lfo_enable_i is high.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_pkt_i/in_valid_i/in_ready_o   upstream sample handshake
//   buf_pkt_o/buf_valid_o        write data and one-cycle write strobe
//   buf_extra_delay_o            LFO value, extra read delay of buffer
//   buf_pkt_delayed_i            registered delayed sample from buffer
//   lfo_enable_i                 1 = LFO advances on output handshake
//   out_pkt_o/out_valid_o/out_ready_i  downstream mix handshake
//
// Optional macro STARTUP_MUTE_EN: the first MUTE_SAMPLES outputs after
// reset use dry in place of wet, hiding uninitialised buffer RAM.
module chorus_delay_ctrl #(
  parameter int unsigned PKT_WIDTH    = 16,
  parameter int unsigned ADDR_WIDTH   = 13,
  parameter int unsigned LFO_DEPTH    = 256,
  parameter int unsigned LFO_STEP     = 1,
  parameter int unsigned MUTE_SAMPLES = 7680
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PKT_WIDTH-1:0]  in_pkt_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [PKT_WIDTH-1:0]  buf_pkt_o,
  output logic                  buf_valid_o,
  output logic [ADDR_WIDTH-1:0] buf_extra_delay_o,
  input  logic [PKT_WIDTH-1:0]  buf_pkt_delayed_i,
  input  logic                  lfo_enable_i,
  output logic [PKT_WIDTH-1:0]  out_pkt_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);

  localparam int unsigned SUM_W = PKT_WIDTH + 1;
  localparam int unsigned LFO_W = ADDR_WIDTH + 1;
  localparam logic [LFO_W-1:0] DEPTH_X = LFO_W'(LFO_DEPTH);
  localparam logic [LFO_W-1:0] STEP_X  = LFO_W'(LFO_STEP);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_READ    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_OUT     = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  buf_valid_q, buf_valid_d;
  logic [PKT_WIDTH-1:0]  buf_pkt_q, buf_pkt_d;
  logic [PKT_WIDTH-1:0]  out_pkt_q, out_pkt_d;
  logic                  out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0] lfo_cnt_q, lfo_cnt_d;
  logic                  lfo_up_q, lfo_up_d;

  logic [PKT_WIDTH-1:0]  wet;
  logic [SUM_W-1:0]      mix_sum;
  logic [PKT_WIDTH-1:0]  mix;
  logic [LFO_W-1:0]      lfo_up_sum;

  // buf_pkt_q doubles as the latched dry sample for the whole transaction.
`ifdef STARTUP_MUTE_EN
  localparam int unsigned MUTE_W = (MUTE_SAMPLES < 1) ? 1 : $clog2(MUTE_SAMPLES + 1);

  logic [MUTE_W-1:0] mute_cnt_q, mute_cnt_d;
  logic              muting;

  assign muting = (mute_cnt_q < MUTE_W'(MUTE_SAMPLES));
  assign wet    = muting ? buf_pkt_q : buf_pkt_delayed_i;

  // Saturating count of samples that reached CAPTURE since reset.
  always_comb begin
    mute_cnt_d = mute_cnt_q;
    if (state_q == ST_CAPTURE && muting) begin
      mute_cnt_d = mute_cnt_q + MUTE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mute_cnt_q <= '0;
    end else begin
      mute_cnt_q <= mute_cnt_d;
    end
  end
`else
  assign wet = buf_pkt_delayed_i;

  // Mute length only matters when the startup mute is built in.
  if (MUTE_SAMPLES == 0) begin : g_mute_len_unused
  end
`endif

  // Average of dry and wet at one extra bit; the shift floors toward -inf.
  always_comb begin
    mix_sum = SUM_W'($signed(buf_pkt_q)) + SUM_W'($signed(wet));
    mix     = PKT_WIDTH'(mix_sum >> 1);
  end

  assign lfo_up_sum = LFO_W'(lfo_cnt_q) + STEP_X;

  // Next-state, output and LFO logic.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    buf_valid_d = 1'b0;
    buf_pkt_d   = buf_pkt_q;
    out_pkt_d   = out_pkt_q;
    out_valid_d = out_valid_q;
    lfo_cnt_d   = lfo_cnt_q;
    lfo_up_d    = lfo_up_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid_i && in_ready_q) begin
          buf_pkt_d   = in_pkt_i;
          buf_valid_d = 1'b1;
          in_ready_d  = 1'b0;
          state_d     = ST_WRITE;
        end
      end
      ST_WRITE:   state_d = ST_READ;
      ST_READ:    state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        out_pkt_d   = mix;
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
          if (lfo_enable_i) begin
            if (lfo_up_q) begin
              if (lfo_up_sum >= DEPTH_X) begin
                lfo_cnt_d = ADDR_WIDTH'(LFO_DEPTH);
                lfo_up_d  = 1'b0;
              end else begin
                lfo_cnt_d = lfo_up_sum[ADDR_WIDTH-1:0];
              end
            end else begin
              if (LFO_W'(lfo_cnt_q) <= STEP_X) begin
                lfo_cnt_d = '0;
                lfo_up_d  = 1'b1;
              end else begin
                lfo_cnt_d = lfo_cnt_q - ADDR_WIDTH'(LFO_STEP);
              end
            end
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      buf_valid_q <= 1'b0;
      buf_pkt_q   <= '0;
      out_pkt_q   <= '0;
      out_valid_q <= 1'b0;
      lfo_cnt_q   <= '0;
      lfo_up_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      buf_valid_q <= buf_valid_d;
      buf_pkt_q   <= buf_pkt_d;
      out_pkt_q   <= out_pkt_d;
      out_valid_q <= out_valid_d;
      lfo_cnt_q   <= lfo_cnt_d;
      lfo_up_q    <= lfo_up_d;
    end
  end

  // Ready drops immediately while reset is held, not only after the edge.
  assign in_ready_o        = in_ready_q & ~rst;
  assign buf_valid_o       = buf_valid_q;
  assign buf_pkt_o         = buf_pkt_q;
  assign buf_extra_delay_o = lfo_cnt_q;
  assign out_pkt_o         = out_pkt_q;
  assign out_valid_o       = out_valid_q;

endmodule

// File: tb/tb_chorus_delay_ctrl.sv
// Self-checking bench for chorus_delay_ctrl: transaction-level reference
// model plus a per-cycle compare process and literal expectations.
module tb_chorus_delay_ctrl;

  localparam int PW    = 16;
  localparam int AW    = 13;
  localparam int DEPTH = 8;
  localparam int STEP  = 3;
  localparam int MUTE  = 4;
`ifdef STARTUP_MUTE_EN
  localparam bit MUTE_ON = 1'b1;
`else
  localparam bit MUTE_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] in_pkt_i = '0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [PW-1:0] buf_pkt_o;
  logic          buf_valid_o;
  logic [AW-1:0] buf_extra_delay_o;
  logic [PW-1:0] buf_pkt_delayed_i = '0;
  logic          lfo_enable_i = 1'b1;
  logic [PW-1:0] out_pkt_o;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;

  always #5 clk = ~clk;

  chorus_delay_ctrl #(
    .PKT_WIDTH(PW), .ADDR_WIDTH(AW), .LFO_DEPTH(DEPTH),
    .LFO_STEP(STEP), .MUTE_SAMPLES(MUTE)
  ) dut (
    .clk(clk), .rst(rst),
    .in_pkt_i(in_pkt_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .buf_pkt_o(buf_pkt_o), .buf_valid_o(buf_valid_o),
    .buf_extra_delay_o(buf_extra_delay_o),
    .buf_pkt_delayed_i(buf_pkt_delayed_i),
    .lfo_enable_i(lfo_enable_i),
    .out_pkt_o(out_pkt_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int tmo_req  = 0;
  int tmo_seen = 0;

  // Literal expectations at each directed output handshake.
  logic [PW-1:0] lit_pkt [0:15];
  int            lit_dly [0:15];
  int            lit_wr = 0;
  int            lit_rd = 0;

  // Delay buffer stand-in: the read registered two edges after the write
  // strobe returns wet_cur; every other cycle carries random garbage.
  logic          wr_seen = 1'b0;
  logic [PW-1:0] wet_cur = '0;
  always @(posedge clk) begin
    wr_seen           <= buf_valid_o;
    buf_pkt_delayed_i <= wr_seen ? wet_cur : 16'($urandom);
  end

  function automatic logic [PW-1:0] mix_ref(input logic [PW-1:0] d, input logic [PW-1:0] w);
    int s;
    int m;
    s = int'($signed(d)) + int'($signed(w));
    if (s >= 0) m = s / 2;
    else        m = -((-s + 1) / 2);
    return 16'(m);
  endfunction

  // Reference model: age counts edges since the accepting edge.
  bit            m_busy = 1'b0;
  int            m_age  = 0;
  bit            m_ov   = 1'b0;
  logic [PW-1:0] m_op   = '0;
  logic [PW-1:0] m_bp   = '0;
  int            m_cnt  = 0;
  bit            m_up   = 1'b1;
  int            m_nout = 0;
  int            m_rst_edges = 0;

  always @(posedge clk) begin : model
    logic [PW-1:0] w;
    if (rst) begin
      m_busy = 1'b0; m_age = 0; m_ov = 1'b0; m_op = '0; m_bp = '0;
      m_cnt = 0; m_up = 1'b1; m_nout = 0;
      m_rst_edges = m_rst_edges + 1;
    end else begin
      m_rst_edges = 0;
      if (m_ov) begin
        if (out_ready_i) begin
          m_ov = 1'b0;
          m_busy = 1'b0;
          if (lfo_enable_i) begin
            if (m_up) begin
              if (m_cnt + STEP >= DEPTH) begin m_cnt = DEPTH; m_up = 1'b0; end
              else m_cnt = m_cnt + STEP;
            end else begin
              if (m_cnt <= STEP) begin m_cnt = 0; m_up = 1'b1; end
              else m_cnt = m_cnt - STEP;
            end
          end
        end
      end else if (!m_busy) begin
        if (in_valid_i) begin
          m_busy = 1'b1;
          m_age = 0;
          m_bp = in_pkt_i;
        end
      end else begin
        m_age = m_age + 1;
        if (m_age == 3) begin
          w = buf_pkt_delayed_i;
          if (MUTE_ON && m_nout < MUTE) w = m_bp;
          m_op = mix_ref(m_bp, w);
          m_ov = 1'b1;
          m_nout = m_nout + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare process, sampled on the falling edge.
  always @(negedge clk) begin
    check("in_ready", 32'(in_ready_o), 32'(!m_busy && !rst));
    check("buf_valid", 32'(buf_valid_o), 32'(m_busy && m_age == 0 && !m_ov));
    if (m_busy && m_age == 0 && !m_ov) check("buf_pkt", 32'(buf_pkt_o), 32'(m_bp));
    check("extra_delay", 32'(buf_extra_delay_o), 32'(m_cnt));
    check("out_valid", 32'(out_valid_o), 32'(m_ov));
    if (m_ov) check("out_pkt", 32'(out_pkt_o), 32'(m_op));
    if (m_rst_edges > 0) begin
      check("rst_out_pkt", 32'(out_pkt_o), 32'h0);
      check("rst_out_valid", 32'(out_valid_o), 32'h0);
      check("rst_buf_valid", 32'(buf_valid_o), 32'h0);
      check("rst_buf_pkt", 32'(buf_pkt_o), 32'h0);
      check("rst_extra_delay", 32'(buf_extra_delay_o), 32'h0);
    end
    if (out_valid_o && out_ready_i && lit_rd < lit_wr) begin
      check("lit_out_pkt", 32'(out_pkt_o), 32'(lit_pkt[lit_rd]));
      check("lit_delay", 32'(buf_extra_delay_o), 32'(lit_dly[lit_rd]));
      lit_rd = lit_rd + 1;
    end
    if (tmo_req != tmo_seen) begin
      tmo_seen = tmo_req;
      n_checks = n_checks + 1;
      n_fail   = n_fail + 1;
      $display("FAIL timeout: handshake wait expired, got none expected handshake at %0t", $time);
    end
  end

  // One directed transaction; optionally aborted by reset while in OUT.
  task automatic do_tx(input logic [PW-1:0] dry, input logic [PW-1:0] wet,
                       input bit en, input int hold, input bit abort,
                       input bit has_lit, input logic [PW-1:0] exp_pkt, input int exp_dly);
    int k;
    if (has_lit) begin
      lit_pkt[lit_wr] = exp_pkt;
      lit_dly[lit_wr] = exp_dly;
      lit_wr = lit_wr + 1;
    end
    wet_cur = wet; in_pkt_i = dry; in_valid_i = 1'b1; lfo_enable_i = en;
    k = 0;
    while (!in_ready_o && k < 50) begin @(posedge clk); #1; k++; end
    if (!in_ready_o) begin tmo_req++; in_valid_i = 1'b0; return; end
    @(posedge clk); #1;
    in_valid_i = (hold > 0);
    in_pkt_i = 16'($urandom);
    k = 0;
    while (!out_valid_o && k < 20) begin @(posedge clk); #1; k++; end
    if (!out_valid_o) begin tmo_req++; in_valid_i = 1'b0; return; end
    if (abort) begin
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b0;
      in_valid_i = 1'b0;
      return;
    end
    repeat (hold) begin @(posedge clk); #1; end
    out_ready_i = 1'b1; in_valid_i = 1'b0;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
  endtask

  int lfo_seq [0:7] = '{0, 3, 6, 8, 5, 2, 0, 3};

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Sample parked in OUT, then reset for 3 cycles.
    do_tx(16'h1234, 16'h0100, 1'b1, 0, 1'b1, 1'b0, 16'h0, 0);
    repeat (3) begin @(posedge clk); #1; end

    // Startup mute / plain mix with the LFO walking its triangle.
    for (int i = 0; i < 5; i++)
      do_tx(16'h2000, 16'h0000, 1'b1, 0, 1'b0, 1'b1,
            (MUTE_ON && i < MUTE) ? 16'h2000 : 16'h1000, lfo_seq[i]);
    do_tx(16'h1000, 16'h0800, 1'b1, 0,  1'b0, 1'b1, 16'h0C00, lfo_seq[5]);
    do_tx(16'h7FFF, 16'h7FFF, 1'b1, 10, 1'b0, 1'b1, 16'h7FFF, lfo_seq[6]);
    do_tx(16'h8000, 16'h8000, 1'b0, 0,  1'b0, 1'b1, 16'h8000, lfo_seq[7]);
    // LFO frozen across three samples.
    do_tx(16'h7FFF, 16'h8000, 1'b0, 0,  1'b0, 1'b1, 16'hFFFF, 3);
    do_tx(16'h0001, 16'h0000, 1'b0, 0,  1'b0, 1'b1, 16'h0000, 3);
    do_tx(16'h1234, 16'h0002, 1'b1, 0,  1'b0, 1'b1, 16'h091B, 3);
    do_tx(16'hFFFF, 16'h0000, 1'b1, 0,  1'b0, 1'b1, 16'hFFFF, 6);

    // Randomised traffic, backpressure and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      in_valid_i   = 1'($urandom_range(0, 1));
      in_pkt_i     = 16'($urandom);
      out_ready_i  = ($urandom_range(0, 9) < 6);
      lfo_enable_i = ($urandom_range(0, 9) < 8);
      case ($urandom_range(0, 3))
        0:       wet_cur = 16'h7FFF;
        1:       wet_cur = 16'h8000;
        default: wet_cur = 16'($urandom);
      endcase
      rst = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    repeat (10) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
